// File: rtl/cpu_debugger_command.sv
// Byte-serial host command engine driving the debugger port of the CPU memory arbiter.
// Optional inter-byte timeout is built only when CPU_DEBUGGER_TIMEOUT_EN is defined.
module cpu_debugger_command #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_rx_valid,
  input  logic [7:0]  i_rx_data,
  output logic        o_rx_ready,
  output logic        o_tx_valid,
  output logic [7:0]  o_tx_data,
  input  logic        i_tx_ready,
  output logic        o_debugger_en,
  output logic        o_debugger_rw,
  output logic [15:0] o_debugger_address,
  output logic [7:0]  o_debugger_data,
  input  logic [7:0]  i_debugger_data,
  output logic        o_busy
);

  // state   | meaning
  // IDLE    | waiting for an opcode byte
  // ADDR_HI | waiting for address high byte
  // ADDR_LO | waiting for address low byte
  // COUNT   | waiting for byte count (0 = 256)
  // WR_DATA | waiting for the next write data byte
  // WR_MEM  | write strobe cycle
  // RD_MEM  | read strobe cycle
  // RD_WAIT | read data returned by the arbiter, captured at the closing edge
  // TX_DATA | presenting a read byte to the host
  // TX_RESP | presenting a one-byte response (ping, write ack, error)
  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_ADDR_HI = 4'd1;
  localparam logic [3:0] S_ADDR_LO = 4'd2;
  localparam logic [3:0] S_COUNT   = 4'd3;
  localparam logic [3:0] S_WR_DATA = 4'd4;
  localparam logic [3:0] S_WR_MEM  = 4'd5;
  localparam logic [3:0] S_RD_MEM  = 4'd6;
  localparam logic [3:0] S_RD_WAIT = 4'd7;
  localparam logic [3:0] S_TX_DATA = 4'd8;
  localparam logic [3:0] S_TX_RESP = 4'd9;

  localparam logic [7:0] RESP_PING  = 8'hA5;
  localparam logic [7:0] RESP_WRACK = 8'h01;
  localparam logic [7:0] RESP_ERR   = 8'hEE;

  logic [3:0]  state;
  logic        is_read;
  logic [15:0] addr;
  logic [8:0]  count;
  logic        operand_wait;
  logic        rx_fire;
  logic        tx_fire;
  logic        timeout_hit;

  assign operand_wait = (state == S_ADDR_HI) || (state == S_ADDR_LO) ||
                        (state == S_COUNT)   || (state == S_WR_DATA);
  // Gated by reset so every output reads 0 while reset is held.
  assign o_rx_ready   = i_reset_n && ((state == S_IDLE) || operand_wait);
  assign rx_fire      = i_rx_valid && o_rx_ready;
  assign tx_fire      = o_tx_valid && i_tx_ready;
  assign o_busy       = (state != S_IDLE);

`ifdef CPU_DEBUGGER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] timeout_cnt;

  // Down-counter reloads on every accepted byte and outside operand states.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n || !operand_wait || rx_fire) begin
      timeout_cnt <= TW'(TIMEOUT_CYCLES - 1);
    end else if (timeout_cnt != '0) begin
      timeout_cnt <= timeout_cnt - 1'b1;
    end
  end

  assign timeout_hit = operand_wait && !rx_fire && (timeout_cnt == '0);
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign timeout_hit        = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state              <= S_IDLE;
      is_read            <= 1'b0;
      addr               <= '0;
      count              <= '0;
      o_tx_valid         <= 1'b0;
      o_tx_data          <= '0;
      o_debugger_en      <= 1'b0;
      o_debugger_rw      <= 1'b0;
      o_debugger_address <= '0;
      o_debugger_data    <= '0;
    end else begin
      o_debugger_en <= 1'b0;
      if (timeout_hit) begin
        state      <= S_TX_RESP;
        o_tx_valid <= 1'b1;
        o_tx_data  <= RESP_ERR;
      end else begin
        case (state)
          S_IDLE: if (rx_fire) begin
            case (i_rx_data)
              8'h00: begin
                state      <= S_TX_RESP;
                o_tx_valid <= 1'b1;
                o_tx_data  <= RESP_PING;
              end
              8'h01: begin
                is_read <= 1'b0;
                state   <= S_ADDR_HI;
              end
              8'h02: begin
                is_read <= 1'b1;
                state   <= S_ADDR_HI;
              end
              default: begin
                state      <= S_TX_RESP;
                o_tx_valid <= 1'b1;
                o_tx_data  <= RESP_ERR;
              end
            endcase
          end
          S_ADDR_HI: if (rx_fire) begin
            addr[15:8] <= i_rx_data;
            state      <= S_ADDR_LO;
          end
          S_ADDR_LO: if (rx_fire) begin
            addr[7:0] <= i_rx_data;
            state     <= S_COUNT;
          end
          S_COUNT: if (rx_fire) begin
            count <= (i_rx_data == 8'h00) ? 9'd256 : {1'b0, i_rx_data};
            if (is_read) begin
              state              <= S_RD_MEM;
              o_debugger_en      <= 1'b1;
              o_debugger_rw      <= 1'b1;
              o_debugger_address <= addr;
            end else begin
              state <= S_WR_DATA;
            end
          end
          S_WR_DATA: if (rx_fire) begin
            state              <= S_WR_MEM;
            o_debugger_en      <= 1'b1;
            o_debugger_rw      <= 1'b0;
            o_debugger_address <= addr;
            o_debugger_data    <= i_rx_data;
          end
          S_WR_MEM: begin
            addr  <= addr + 16'd1;
            count <= count - 9'd1;
            if (count == 9'd1) begin
              state      <= S_TX_RESP;
              o_tx_valid <= 1'b1;
              o_tx_data  <= RESP_WRACK;
            end else begin
              state <= S_WR_DATA;
            end
          end
          S_RD_MEM: begin
            addr  <= addr + 16'd1;
            count <= count - 9'd1;
            state <= S_RD_WAIT;
          end
          S_RD_WAIT: begin
            o_tx_valid <= 1'b1;
            o_tx_data  <= i_debugger_data;
            state      <= S_TX_DATA;
          end
          S_TX_DATA: if (tx_fire) begin
            o_tx_valid <= 1'b0;
            if (count == 9'd0) begin
              state <= S_IDLE;
            end else begin
              state              <= S_RD_MEM;
              o_debugger_en      <= 1'b1;
              o_debugger_rw      <= 1'b1;
              o_debugger_address <= addr;
            end
          end
          S_TX_RESP: if (tx_fire) begin
            o_tx_valid <= 1'b0;
            state      <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cpu_debugger_command.sv
// Bench for cpu_debugger_command: command table with scoreboard queues, plus timing,
// backpressure, reset and (when CPU_DEBUGGER_TIMEOUT_EN is defined) timeout sequences.
module tb_cpu_debugger_command;

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic        i_rx_valid;
  logic [7:0]  i_rx_data;
  logic        o_rx_ready;
  logic        o_tx_valid;
  logic [7:0]  o_tx_data;
  logic        i_tx_ready;
  logic        o_debugger_en;
  logic        o_debugger_rw;
  logic [15:0] o_debugger_address;
  logic [7:0]  o_debugger_data;
  logic [7:0]  i_debugger_data;
  logic        o_busy;

  cpu_debugger_command #(.TIMEOUT_CYCLES(16)) dut (
    .i_clk              (i_clk),
    .i_reset_n          (i_reset_n),
    .i_rx_valid         (i_rx_valid),
    .i_rx_data          (i_rx_data),
    .o_rx_ready         (o_rx_ready),
    .o_tx_valid         (o_tx_valid),
    .o_tx_data          (o_tx_data),
    .i_tx_ready         (i_tx_ready),
    .o_debugger_en      (o_debugger_en),
    .o_debugger_rw      (o_debugger_rw),
    .o_debugger_address (o_debugger_address),
    .o_debugger_data    (o_debugger_data),
    .i_debugger_data    (i_debugger_data),
    .o_busy             (o_busy)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic        rw;
    logic [15:0] addr;
    logic [7:0]  data;
  } acc_t;

  typedef struct {
    string       name;
    int          nb;
    logic [63:0] cmd;
    int          nt;
    logic [31:0] tx;
  } vec_t;

  acc_t       accq[$];
  logic [7:0] txq[$];
  logic [7:0] arb_mem [int];
  int         tests = 0;
  int         failed = 0;
  acc_t       mon_acc;
  logic [7:0] mon_tx;
  vec_t       vecs[8];

  function automatic logic [7:0] mem_rd(input logic [15:0] a);
    return arb_mem.exists(int'(a)) ? arb_mem[int'(a)] : 8'h00;
  endfunction

  // Arbiter model: debugger access completes in its strobe cycle, read data next cycle.
  always @(posedge i_clk) begin
    if (o_debugger_en) begin
      if (o_debugger_rw) i_debugger_data <= mem_rd(o_debugger_address);
      else arb_mem[int'(o_debugger_address)] = o_debugger_data;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge i_clk) begin
    if (i_reset_n === 1'b1) begin
      if (o_debugger_en) begin
        if (accq.size() == 0) begin
          tests++; failed++;
          $display("FAIL unexpected_en: addr %0h rw %0b", o_debugger_address, o_debugger_rw);
        end else begin
          mon_acc = accq.pop_front();
          check("en_rw", o_debugger_rw, mon_acc.rw);
          check("en_addr", o_debugger_address, mon_acc.addr);
          if (!mon_acc.rw) check("en_wdata", o_debugger_data, mon_acc.data);
        end
      end
      if (o_tx_valid && i_tx_ready) begin
        if (txq.size() == 0) begin
          tests++; failed++;
          $display("FAIL unexpected_tx: got %0h", o_tx_data);
        end else begin
          mon_tx = txq.pop_front();
          check("tx_byte", o_tx_data, mon_tx);
        end
      end
    end
  end

  // Expected debugger accesses derived from the command bytes.
  task automatic model_cmd(input logic [7:0] c[$]);
    logic [15:0] a;
    int n;
    if (c.size() >= 4 && (c[0] == 8'h01 || c[0] == 8'h02)) begin
      a = {c[1], c[2]};
      n = (c[3] == 8'h00) ? 256 : int'(c[3]);
      for (int i = 0; i < n; i++) begin
        if (c[0] == 8'h01) accq.push_back('{rw: 1'b0, addr: a, data: c[4+i]});
        else accq.push_back('{rw: 1'b1, addr: a, data: 8'h00});
        a = a + 16'd1;
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    i_rx_valid = 1'b1;
    i_rx_data  = b;
    forever begin
      @(negedge i_clk);
      if (o_rx_ready) break;
      n++;
      if (n > 200) begin
        tests++; failed++;
        $display("FAIL rx_stall: byte %0h not accepted", b);
        break;
      end
      @(posedge i_clk); #1;
    end
    @(posedge i_clk); #1;
    i_rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    forever begin
      @(negedge i_clk);
      if (!o_busy && !o_tx_valid && txq.size() == 0 && accq.size() == 0) break;
      n++;
      if (n > 2000) break;
      @(posedge i_clk); #1;
    end
    check({name, "_busy"}, o_busy, 1'b0);
    check({name, "_pending"}, txq.size() + accq.size(), 0);
    @(posedge i_clk); #1;
  endtask

  task automatic send_seq(input logic [7:0] c[$]);
    foreach (c[i]) send_byte(c[i]);
  endtask

  initial begin
    logic [7:0] q[$];
    int early;

    arb_mem[16'hFFFF] = 8'h5A;
    arb_mem[16'h0000] = 8'h6B;
    i_reset_n = 1'b0; i_rx_valid = 1'b0; i_rx_data = 8'h00;
    i_tx_ready = 1'b0; i_debugger_data = 8'h00;

    vecs[0] = '{name: "ping",      nb: 1, cmd: 64'h00000000_00000000, nt: 1, tx: 32'hA5000000};
    vecs[1] = '{name: "write3",    nb: 7, cmd: 64'h01123403_AABBCC00, nt: 1, tx: 32'h01000000};
    vecs[2] = '{name: "read_wrap", nb: 4, cmd: 64'h02FFFF02_00000000, nt: 2, tx: 32'h5A6B0000};
    vecs[3] = '{name: "readback",  nb: 4, cmd: 64'h02123502_00000000, nt: 2, tx: 32'hBBCC0000};
    vecs[4] = '{name: "bad_7f",    nb: 1, cmd: 64'h7F000000_00000000, nt: 1, tx: 32'hEE000000};
    vecs[5] = '{name: "bad_ff",    nb: 1, cmd: 64'hFF000000_00000000, nt: 1, tx: 32'hEE000000};
    vecs[6] = '{name: "write_top", nb: 5, cmd: 64'h01FFFF01_11000000, nt: 1, tx: 32'h01000000};
    vecs[7] = '{name: "read_top",  nb: 4, cmd: 64'h02FFFF01_00000000, nt: 1, tx: 32'h11000000};

    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check("rst_tx_valid", o_tx_valid, 1'b0);
    check("rst_tx_data", o_tx_data, 8'h00);
    check("rst_en", o_debugger_en, 1'b0);
    check("rst_rw", o_debugger_rw, 1'b0);
    check("rst_addr", o_debugger_address, 16'h0000);
    check("rst_wdata", o_debugger_data, 8'h00);
    check("rst_busy", o_busy, 1'b0);
    check("rst_rx_ready", o_rx_ready, 1'b0);
    @(posedge i_clk); #1;
    i_reset_n  = 1'b1;
    i_tx_ready = 1'b1;
    @(posedge i_clk); #1;

    foreach (vecs[v]) begin
      q = {};
      for (int i = 0; i < vecs[v].nb; i++) q.push_back(vecs[v].cmd[63-8*i -: 8]);
      model_cmd(q);
      for (int i = 0; i < vecs[v].nt; i++) txq.push_back(vecs[v].tx[31-8*i -: 8]);
      send_seq(q);
      wait_idle(vecs[v].name);
    end

    // Write strobe lands in the cycle after each data byte, with rx held off.
    q = '{8'h01, 8'h20, 8'h00, 8'h02, 8'h55, 8'h66};
    model_cmd(q);
    txq.push_back(8'h01);
    send_seq('{8'h01, 8'h20, 8'h00, 8'h02, 8'h55});
    @(negedge i_clk);
    check("wr_t_en", o_debugger_en, 1'b1);
    check("wr_t_rw", o_debugger_rw, 1'b0);
    check("wr_t_rx_ready", o_rx_ready, 1'b0);
    check("wr_t_addr", o_debugger_address, 16'h2000);
    @(posedge i_clk); #1;
    send_byte(8'h66);
    @(negedge i_clk);
    check("wr_t2_en", o_debugger_en, 1'b1);
    check("wr_t2_data", o_debugger_data, 8'h66);
    @(negedge i_clk);
    check("wr_ack_valid", o_tx_valid, 1'b1);
    @(posedge i_clk); #1;
    wait_idle("wr_timing");

    // Read latency and TX backpressure.
    i_tx_ready = 1'b0;
    q = '{8'h02, 8'h12, 8'h34, 8'h01};
    model_cmd(q);
    txq.push_back(8'hAA);
    send_seq(q);
    @(negedge i_clk);
    check("rd_t_en", o_debugger_en, 1'b1);
    check("rd_t_rw", o_debugger_rw, 1'b1);
    @(negedge i_clk);
    check("rd_t1_valid", {o_debugger_en, o_tx_valid}, 2'b00);
    @(negedge i_clk);
    check("rd_t2_valid", o_tx_valid, 1'b1);
    early = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge i_clk);
      if (o_tx_valid !== 1'b1 || o_tx_data !== 8'hAA || o_debugger_en !== 1'b0) early++;
    end
    check("bp_stable_bad_cycles", early, 0);
    @(posedge i_clk); #1;
    i_tx_ready = 1'b1;
    wait_idle("backpressure");

    // Reset after addr_lo discards the write.
    send_seq('{8'h01, 8'h40, 8'h00});
    i_reset_n = 1'b0;
    @(posedge i_clk); #1;
    @(negedge i_clk);
    check("mid_rst_outputs",
          {o_rx_ready, o_tx_valid, o_tx_data, o_debugger_en, o_debugger_rw,
           o_debugger_address, o_debugger_data, o_busy}, 32'h0);
    @(posedge i_clk); #1;
    i_reset_n = 1'b1;
    repeat (5) @(posedge i_clk);
    #1;
    wait_idle("after_rst");
    txq.push_back(8'hA5);
    send_byte(8'h00);
    wait_idle("ping_after_rst");

`ifdef CPU_DEBUGGER_TIMEOUT_EN
    txq.push_back(8'hEE);
    send_seq('{8'h02, 8'h00});
    early = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge i_clk);
      if (o_tx_valid !== 1'b0 || o_busy !== 1'b1) early++;
    end
    check("to_early", early, 0);
    @(negedge i_clk);
    check("to_resp", {o_tx_valid, o_tx_data}, {1'b1, 8'hEE});
    @(posedge i_clk); #1;
    wait_idle("timeout");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
